ir_blob_decoder: RTL and testbench
==================================

Name: ir_blob_decoder

Overview:
Parses the byte stream read from the IR camera over I2C in extended-mode frames and extracts the first blob's 10-bit x/y position and 4-bit size. Sits directly upstream of the x/y LED indicator and the drawing logic, and presents a registered, held position plus a one-cycle update strobe. Tracks whether the pen is visible and drops a tracking flag after a configurable number of clock cycles without a valid blob.

Parameters:
NUM_BLOBS, 4, blob records per frame; blobs 1..NUM_BLOBS-1 are consumed and discarded
TIMEOUT, 1200000, clock cycles without a valid blob before tracking deasserts (100 ms at 12 MHz)
RESET_X, 512, x value loaded at reset
RESET_Y, 384, y value loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sof  in  1  start-of-frame pulse from the I2C reader
data  in  8  received byte
data_valid  in  1  data holds a new byte this cycle
x  out  10  last valid blob x
y  out  10  last valid blob y
size  out  4  last valid blob size
xy_valid  out  1  one-cycle pulse: x/y/size just updated
tracking  out  1  high while a valid blob has been seen within TIMEOUT cycles
frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset values:
  - x=RESET_X, y=RESET_Y, size=0.
  - xy_valid=0, tracking=0, frame_err=0.
  - FSM in IDLE; timeout counter 0.
- Frame format: 1 header byte followed by NUM_BLOBS x 3 bytes, giving 13 bytes by default.
- Blob byte mapping:
  - b0 = x[7:0]
  - b1 = y[7:0]
  - b2[7:6] = y[9:8], b2[5:4] = x[9:8], b2[3:0] = size
- Blob absent encoding: assembled x==0x3FF and y==0x3FF.
- FSM states: IDLE, HEADER, BLOB, DONE.
  - IDLE: waits for sof. On sof, moves to HEADER and clears the byte counter.
  - HEADER: the first data_valid byte is discarded; moves to BLOB.
  - BLOB: counts bytes 0..3*NUM_BLOBS-1.
    - Bytes 0..2 (blob 0) are captured into staging registers. Outputs are not touched.
    - After the last byte, moves to DONE.
  - DONE: holds until the next sof.
- Output update: on the last byte of the frame, if the staged blob is present:
  - x/y/size load on the next clock edge; xy_valid pulses in that same cycle (1-cycle latency from the last byte).
  - tracking is set; timeout counter cleared.
- If the staged blob is absent: no output update, no xy_valid, and the timeout counter keeps running.
- Timeout counter:
  - Increments every cycle while tracking=1 and saturates.
  - When it reaches TIMEOUT-1, tracking clears the next cycle.
  - x/y/size hold their last values.
- sof while in HEADER or BLOB: the current frame is aborted with no output update, frame_err pulses one cycle, and the FSM restarts at HEADER.
- sof with data_valid in the same cycle: the byte is treated as the new frame's header byte, so the FSM goes directly to BLOB with counter 0.
- data_valid in DONE or IDLE (extra or orphan bytes): ignored. frame_err pulses once per frame on the first such byte in DONE; bytes in IDLE are silent.
- data_valid low cycles between bytes are allowed; the FSM simply holds.
- Reset mid-frame: the partial frame is discarded, all outputs return to reset values, and the FSM returns to IDLE.
- xy_valid and frame_err never assert in the same cycle.

Test Plan:
- Reset then idle 100 cycles -> x=512, y=384, size=0, tracking=0, xy_valid never high.
- sof, bytes 0x00,0x34,0x12,0x95 then 9 x 0xFF -> one cycle after the 13th byte: x=308, y=530, size=5, xy_valid=1 for exactly 1 cycle, tracking=1.
- Valid frame, then a frame with blob0 bytes 0xFF,0xFF,0xFF -> no xy_valid, x/y stay 308/530. With TIMEOUT=50: tracking drops exactly 50 cycles after the last update.
- sof, header plus 5 bytes, then sof again plus a full valid frame (x=100,y=200) -> frame_err pulses once at the second sof; outputs update only from the second frame.
- Valid frame followed by 2 extra bytes before the next sof -> frame_err pulses once on the first extra byte; outputs unchanged.
- Assert reset at byte 7 of a frame, then send a full valid frame -> outputs at reset values until the new frame completes, then the new values and a single xy_valid.

Source files
------------

// File: rtl/ir_blob_decoder.sv
// ir_blob_decoder: parses IR-camera extended-mode frames and extracts blob 0 position/size.
// Latency: x/y/size/xy_valid update one clock after the last byte of a frame.
// Backpressure: none; bytes are accepted whenever data_valid is high and are never stalled.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sof                 start-of-frame pulse (may coincide with the header byte)
//   data, data_valid    received byte stream from the I2C reader
//   x, y, size          last valid blob 0 position and size (held between updates)
//   xy_valid            one-cycle strobe when x/y/size load
//   tracking            high while a valid blob was seen within TIMEOUT cycles
//   frame_err           one-cycle strobe on an aborted frame or surplus bytes after a frame
module ir_blob_decoder #(
  parameter int NUM_BLOBS = 4,
  parameter int TIMEOUT   = 1200000,
  parameter int RESET_X   = 512,
  parameter int RESET_Y   = 384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sof,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] size,
  output logic       xy_valid,
  output logic       tracking,
  output logic       frame_err
);

  localparam int BLOB_BYTES = 3 * NUM_BLOBS;
  localparam int CW         = (BLOB_BYTES > 2) ? $clog2(BLOB_BYTES) : 2;
  localparam int TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(BLOB_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HEADER, BLOB, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] to_cnt;
  logic          extra_seen;   // surplus byte already flagged for this frame
  logic [7:0]    stg_b0;
  logic [7:0]    stg_b1;
  logic [7:0]    stg_b2;

  // Candidate blob 0. When there is only one blob record the third byte is
  // also the last byte of the frame, so it is taken straight off the bus.
  logic [7:0] b2_now;
  logic [9:0] cand_x;
  logic [9:0] cand_y;
  logic       cand_present;

  always_comb begin
    b2_now       = (cnt == CW'(2)) ? data : stg_b2;
    cand_x       = {b2_now[5:4], stg_b0};
    cand_y       = {b2_now[7:6], stg_b1};
    cand_present = !((cand_x == 10'h3FF) && (cand_y == 10'h3FF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      to_cnt     <= '0;
      extra_seen <= 1'b0;
      stg_b0     <= '0;
      stg_b1     <= '0;
      stg_b2     <= '0;
      x          <= 10'(RESET_X);
      y          <= 10'(RESET_Y);
      size       <= '0;
      xy_valid   <= 1'b0;
      tracking   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      xy_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Timeout: saturating count while tracking; a blob update below
      // overrides both the count and the tracking flag.
      if (tracking) begin
        if (to_cnt == TO_LAST) begin
          tracking <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end

      if (sof) begin
        // A new frame always wins, even over the last byte of the current one.
        if ((state == HEADER) || (state == BLOB)) begin
          frame_err <= 1'b1;
        end
        cnt        <= '0;
        extra_seen <= 1'b0;
        // A byte arriving with sof is that frame's header byte.
        state      <= data_valid ? BLOB : HEADER;
      end else begin
        case (state)
          IDLE: begin
            // Orphan bytes before any frame are dropped silently.
          end
          HEADER: begin
            if (data_valid) begin
              state <= BLOB;
              cnt   <= '0;
            end
          end
          BLOB: begin
            if (data_valid) begin
              if (cnt == CW'(0)) stg_b0 <= data;
              if (cnt == CW'(1)) stg_b1 <= data;
              if (cnt == CW'(2)) stg_b2 <= data;
              if (cnt == LAST_IDX) begin
                state      <= DONE;
                extra_seen <= 1'b0;
                if (cand_present) begin
                  x        <= cand_x;
                  y        <= cand_y;
                  size     <= b2_now[3:0];
                  xy_valid <= 1'b1;
                  tracking <= 1'b1;
                  to_cnt   <= '0;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          DONE: begin
            if (data_valid && !extra_seen) begin
              frame_err  <= 1'b1;
              extra_seen <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Bench for ir_blob_decoder: randomized frames, aborts, surplus bytes and resets,
// with expected blob updates and error strobes queued at stimulus time and
// consumed by an independent negedge monitor.
module tb_ir_blob_decoder;

  localparam int NB      = 4;
  localparam int FB      = 1 + 3 * NB;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic [9:0] x;
  logic [9:0] y;
  logic [3:0] size;
  logic       xy_valid;
  logic       tracking;
  logic       frame_err;

  ir_blob_decoder #(
    .NUM_BLOBS(NB),
    .TIMEOUT  (TIMEOUT),
    .RESET_X  (512),
    .RESET_Y  (384)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sof       (sof),
    .data      (data),
    .data_valid(data_valid),
    .x         (x),
    .y         (y),
    .size      (size),
    .xy_valid  (xy_valid),
    .tracking  (tracking),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] size;
  } exp_t;

  exp_t       sb_q[$];   // popped when the DUT strobes xy_valid
  exp_t       tl_q[$];   // popped by time to model the held outputs
  int         fe_q[$];   // due cycles of expected frame_err strobes
  exp_t       cur;
  bit         has_upd;
  bit         started = 1'b0;
  bit         m_in_frame;
  bit         m_armed;
  logic [7:0] frm [0:FB-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic bad(input string nm, input int act, input int exp_v);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
  endtask

  task automatic clear_model();
    sb_q.delete();
    tl_q.delete();
    fe_q.delete();
    cur.due    = 0;
    cur.x      = 10'd512;
    cur.y      = 10'd384;
    cur.size   = 4'd0;
    has_upd    = 1'b0;
    m_in_frame = 1'b0;
    m_armed    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int mx);
    repeat ($urandom_range(0, mx)) tick();
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic s);
    sof        = s;
    data       = b;
    data_valid = 1'b1;
    tick();
    sof        = 1'b0;
    data_valid = 1'b0;
    data       = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic set_frm(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] fill);
    frm[0] = h;
    frm[1] = b0;
    frm[2] = b1;
    frm[3] = b2;
    for (int i = 4; i < FB; i++) frm[i] = fill;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < FB; i++) frm[i] = 8'($urandom);
    case ($urandom_range(0, 4))
      0: begin frm[1] = 8'hFF; frm[2] = 8'hFF; frm[3][7:4] = 4'hF; end
      1: begin frm[1] = 8'hFF; frm[3][5:4] = 2'b11; end
      default: ;
    endcase
  endtask

  // Blob 0 of the frame: x = {b2[5:4], b0}, y = {b2[7:6], b1}; all-ones x and y means absent.
  task automatic expect_frame(input int due);
    exp_t e;
    e.due  = due;
    e.x    = {frm[3][5:4], frm[1]};
    e.y    = {frm[3][7:6], frm[2]};
    e.size = frm[3][3:0];
    if (!(e.x == 10'h3FF && e.y == 10'h3FF)) begin
      sb_q.push_back(e);
      tl_q.push_back(e);
    end
  endtask

  // Sends sof, header and nblob blob bytes; nblob < 3*NB leaves the frame open.
  task automatic send_frame(input bit merge, input int nblob, input int gmax);
    if (m_in_frame) fe_q.push_back(cyc + 1);
    if (merge) begin
      drive_byte(frm[0], 1'b1);
    end else begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      gap(gmax);
      drive_byte(frm[0], 1'b0);
    end
    m_in_frame = 1'b1;
    m_armed    = 1'b0;
    for (int i = 1; i <= nblob; i++) begin
      gap(gmax);
      if (i == 3 * NB) expect_frame(cyc + 1);
      drive_byte(frm[i], 1'b0);
    end
    if (nblob == 3 * NB) begin
      m_in_frame = 1'b0;
      m_armed    = 1'b1;
    end
  endtask

  task automatic send_extra(input int n);
    for (int i = 0; i < n; i++) begin
      gap(1);
      if (m_armed) begin
        fe_q.push_back(cyc + 1);
        m_armed = 1'b0;
      end
      drive_byte(8'($urandom), 1'b0);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   fd;
    if (started && !reset) begin
      while (tl_q.size() > 0 && tl_q[0].due <= cyc) begin
        cur     = tl_q.pop_front();
        has_upd = 1'b1;
      end
      chk("hold_x", int'(x), int'(cur.x));
      chk("hold_y", int'(y), int'(cur.y));
      chk("hold_size", int'(size), int'(cur.size));
      chk("tracking", int'(tracking), (has_upd && (cyc - cur.due) < TIMEOUT) ? 1 : 0);
      chk("xy_and_err", int'(xy_valid & frame_err), 0);

      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        bad("xy_valid_missing", 0, 1);
      end
      if (xy_valid) begin
        if (sb_q.size() == 0) begin
          bad("xy_valid_spurious", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("xy_cycle", cyc, e.due);
          chk("xy_x", int'(x), int'(e.x));
          chk("xy_y", int'(y), int'(e.y));
          chk("xy_size", int'(size), int'(e.size));
        end
      end

      if (fe_q.size() > 0 && fe_q[0] < cyc) begin
        fd = fe_q.pop_front();
        bad("frame_err_missing", 0, 1);
      end
      if (frame_err) begin
        if (fe_q.size() == 0) begin
          bad("frame_err_spurious", 1, 0);
        end else begin
          fd = fe_q.pop_front();
          chk("frame_err_cycle", cyc, fd);
        end
      end
    end
  end

  initial begin
    int act;
    clear_model();
    repeat (3) tick();
    reset   = 1'b0;
    started = 1'b1;

    // Idle after reset
    repeat (100) tick();
    chk("t1_x", int'(x), 512);
    chk("t1_y", int'(y), 384);
    chk("t1_size", int'(size), 0);
    chk("t1_tracking", int'(tracking), 0);

    // Basic valid frame
    set_frm(8'h00, 8'h34, 8'h12, 8'h95, 8'hFF);
    send_frame(1'b0, 3 * NB, 0);
    chk("t2_xy_valid", int'(xy_valid), 1);
    chk("t2_x", int'(x), 308);
    chk("t2_y", int'(y), 530);
    chk("t2_size", int'(size), 5);
    chk("t2_tracking", int'(tracking), 1);
    tick();
    chk("t2_pulse_width", int'(xy_valid), 0);

    // Absent blob: outputs hold, tracking times out
    set_frm(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    send_frame(1'b1, 3 * NB, 0);
    chk("t3_xy_valid", int'(xy_valid), 0);
    chk("t3_x", int'(x), 308);
    chk("t3_y", int'(y), 530);
    repeat (60) tick();
    chk("t3_tracking_dropped", int'(tracking), 0);

    // Aborted frame followed by a full one
    set_frm(8'h00, 8'h64, 8'hC8, 8'h03, 8'h5A);
    send_frame(1'b0, 5, 0);
    send_frame(1'b0, 3 * NB, 0);
    chk("t4_x", int'(x), 100);
    chk("t4_y", int'(y), 200);
    chk("t4_size", int'(size), 3);

    // Surplus bytes after a frame
    send_extra(2);
    repeat (3) tick();
    chk("t5_x", int'(x), 100);

    // Reset in the middle of a frame
    rand_frame();
    send_frame(1'b0, 6, 0);
    do_reset();
    chk("t6_x_reset", int'(x), 512);
    chk("t6_y_reset", int'(y), 384);
    set_frm(8'h11, 8'h2A, 8'h55, 8'h6C, 8'h00);
    send_frame(1'b1, 3 * NB, 1);
    chk("t6_x", int'(x), 554);
    chk("t6_y", int'(y), 341);
    chk("t6_size", int'(size), 12);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 19);
      if (act < 11) begin
        rand_frame();
        send_frame(1'($urandom_range(0, 1)), 3 * NB, 2);
      end else if (act < 14) begin
        rand_frame();
        send_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3 * NB - 1), 2);
        rand_frame();
        send_frame(1'($urandom_range(0, 1)), 3 * NB, 2);
      end else if (act < 17) begin
        send_extra($urandom_range(1, 3));
      end else if (act < 19) begin
        repeat ($urandom_range(5, 70)) tick();
      end else begin
        do_reset();
      end
    end

    repeat (80) tick();
    chk("xy_queue_drained", sb_q.size(), 0);
    chk("frame_err_queue_drained", fe_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
